rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
Shares one synchronous-read ROM (rom_4_bit style: clk, en, addr, data) between NUM_REQ requesters.
Per-requester valid/ready request handshake; round-robin grant; drives ROM en/addr; returns captured data with a one-cycle response strobe to the granted requester. One read in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, ROM address width
DATA_W, 4, ROM data width
ROM_LAT, 1, cycles from ROM sampling en/addr to rom_data valid (1..4)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  request i pending; held with req_addr until accepted
req_addr  in  NUM_REQ*ADDR_W  packed; slice i = [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot grant, combinational, only in IDLE
rsp_valid  out  NUM_REQ  one-hot one-cycle response strobe, registered
rsp_data  out  DATA_W  response data, shared, valid while rsp_valid != 0
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM address
rom_data  in  DATA_W  ROM read data
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, rr pointer=0, rom_en=0, rom_addr=0, rsp_valid=0, rsp_data=0, wait counter=0. Mid-operation reset aborts the read; no rsp_valid is ever issued for it.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, grant = first requester with req_valid at or after rr pointer (wrapping). req_ready[grant]=1 in the same cycle. At the edge: latch grant index and address, pointer <= (grant+1) mod NUM_REQ, go to ISSUE. No req_valid: stay, pointer unchanged.
- ISSUE: rom_en=1, rom_addr=latched address, exactly one cycle. Then go to WAIT, counter=ROM_LAT-1.
- WAIT: rom_en=0, rom_addr holds its value. While counter!=0, decrement. When counter==0, at that edge capture rsp_data<=rom_data, set rsp_valid[grant]=1, go to RESP.
- RESP: rsp_valid one-hot high for this cycle only. At the edge clear rsp_valid and return to IDLE. A new grant is possible in the following cycle.
- Latency: accept edge E0 -> rom_en high E0..E1 -> rsp_valid high between E(1+ROM_LAT) and E(2+ROM_LAT). Minimum spacing between accepts is ROM_LAT+3 cycles.
- req_ready is 0 in all states but IDLE. req_valid dropped before acceptance is legal; no request is recorded.
- Simultaneous requests: exactly one granted per IDLE cycle. Losers keep req_valid and are served in rr order.
- NUM_REQ not a power of two: the pointer wraps at NUM_REQ-1 -> 0.
- rsp_data holds its last value after RESP until the next capture.

Optional Feature:
ROM_ARB_FIXED_PRIO_EN:
- Defined: fixed priority, lowest index wins; rr pointer removed.
- Undefined (default): round-robin as above.
- All other timing is identical in both modes.

Decomposition:
- Shared package rom_arb_pkg: state encoding localparams (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3) and the ROM_LAT range limits.
- One sub-module, rr_arbiter: inputs req vector and pointer; output one-hot grant and grant index. Purely combinational, and the only place the ROM_ARB_FIXED_PRIO_EN selection lives.
- rom_arbiter holds the FSM, counter, latches and pointer register.

Test Plan:
Bench ROM model returns data=~addr, with ROM_LAT latency.
1. Single read: req0 addr=4'h3 at E0 -> rom_en one cycle with rom_addr=4'h3; rsp_valid=2'b01, rsp_data=4'hC at E(1+ROM_LAT); busy low after RESP.
2. Contention: req0=4'h1 and req1=4'h2 held after reset -> req0 served first (rsp 4'hE), then req1 (rsp 4'hD); then req0 again only if still valid. Grants alternate 0,1,0,1 under continuous requests.
3. Fixed priority (macro defined): both requesters continuously valid -> req0 always granted, req1 never granted (starvation expected).
4. Reset mid-read: assert rst during WAIT -> next cycle busy=0, rom_en=0, rsp_valid=0; no response ever appears for the aborted address; pointer=0.
5. ROM_LAT=3, NUM_REQ=3, req2 only, addr=4'hF -> rsp_valid=3'b100, rsp_data=4'h0, exactly 4 cycles after the accept edge.
6. Withdrawn request: req1 valid while busy, then dropped before IDLE -> no grant to req1 and no rom_en; pointer unchanged.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for rom_arbiter: FSM state encoding and supported ROM latency range.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int ROM_LAT_MIN = 1;
    localparam int ROM_LAT_MAX = 4;
    // Wide enough to hold ROM_LAT_MAX-1.
    localparam int CNT_W       = 2;

endpackage

// File: rtl/rom_arbiter_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant selection for rom_arbiter.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, pointer ignored).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   grant_idx_o,
    output logic               grant_vld_o
);

    // Scan from the farthest candidate to the nearest so the nearest match is the last written.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_idx_o = PTR_W'(i);
                grant_vld_o = 1'b1;
            end else begin
                grant_vld_o = grant_vld_o;
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin : scan
            int idx;
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (req_i[idx]) begin
                grant_idx_o = PTR_W'(idx);
                grant_vld_o = 1'b1;
            end else begin
                grant_vld_o = grant_vld_o;
            end
        end
`endif
        if (grant_vld_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end else begin
            grant_o = '0;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous-read ROM between NUM_REQ requesters, one read in flight.
// Build option ROM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin (inside rr_arbiter).
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int LAT_C = (ROM_LAT < ROM_LAT_MIN) ? ROM_LAT_MIN :
                           (ROM_LAT > ROM_LAT_MAX) ? ROM_LAT_MAX : ROM_LAT;

    arb_state_e          state_q;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rom_en_q;
    logic [ADDR_W-1:0]   rom_addr_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_vld;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .grant_vld_o (arb_vld)
    );

    // Pointer advances past the winner on accept, wrapping at NUM_REQ-1 for non-power-of-two counts.
    always_comb begin
        ptr_d = ptr_q;
        if ((state_q == IDLE) && arb_vld) begin
            if (arb_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = arb_idx + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Read sequencing FSM: accept, one-cycle ROM enable, latency wait, one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            cnt_q       <= '0;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            case (state_q)
                IDLE: begin
                    if (arb_vld) begin
                        gnt_q      <= arb_grant;
                        rom_addr_q <= req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                        rom_en_q   <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    rom_en_q <= 1'b0;
                    cnt_q    <= CNT_W'(LAT_C - 1);
                    state_q  <= WAIT;
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        rsp_data_q  <= rom_data;
                        rsp_valid_q <= gnt_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
                default: begin
                    rom_en_q    <= 1'b0;
                    rsp_valid_q <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE) ? arb_grant : '0;
    assign busy      = (state_q != IDLE);
    assign rom_en    = rom_en_q;
    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (2 req / lat 1 and 3 req / lat 3) with ROM models returning ~addr.
module tb_rom_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [1:0]  va, rdy_a, rv_a;
    logic [7:0]  aa;
    logic [3:0]  rd_a, radr_a, rom_d_a;
    logic        en_a, bz_a;
    logic [2:0]  vb, rdy_b, rv_b;
    logic [11:0] ab;
    logic [3:0]  rd_b, radr_b, rom_d_b;
    logic        en_b, bz_b;

    rom_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(4), .ROM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .req_valid(va), .req_addr(aa), .req_ready(rdy_a),
        .rsp_valid(rv_a), .rsp_data(rd_a), .rom_en(en_a), .rom_addr(radr_a),
        .rom_data(rom_d_a), .busy(bz_a));

    rom_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(4), .ROM_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(vb), .req_addr(ab), .req_ready(rdy_b),
        .rsp_valid(rv_b), .rsp_data(rd_b), .rom_en(en_b), .rom_addr(radr_b),
        .rom_data(rom_d_b), .busy(bz_b));

    // ROM models: data = ~addr, ROM_LAT register stages after the sampling edge.
    logic [3:0] pa;
    logic [3:0] pb [0:2];
    always @(posedge clk) begin
        if (en_a) pa <= ~radr_a;
        if (en_b) pb[0] <= ~radr_b;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign rom_d_a = pa;
    assign rom_d_b = pb[2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level reference: each accept schedules its enable and response cycles.
    typedef struct {
        int busy_until;
        int en_cyc;
        int rsp_cyc;
        int rsp_req;
        int ptr;
        int addr_hold;
        int pend_data;
        int cur_data;
    } mdl_t;

    mdl_t ma, mb;
    int   cyc = 0;

    task automatic mdl_cycle(input string tag, input mdl_t mi, input int n, input int lat,
                             input logic rst_v, input logic [7:0] vld, input logic [31:0] addrs,
                             input logic [7:0] ready, input logic en, input logic [3:0] raddr,
                             input logic [7:0] rv, input logic [3:0] rd, input logic bz,
                             output mdl_t mo);
        mdl_t       m;
        bit         idle;
        int         g, i, exp_ready, exp_rv;
        logic [3:0] av, dv;
        m = mi;
        if (rst_v) begin
            m.busy_until = cyc;
            m.en_cyc     = -1;
            m.rsp_cyc    = -1;
            m.ptr        = 0;
            m.addr_hold  = 0;
            m.cur_data   = 0;
        end else begin
            idle = (cyc > m.busy_until);
            g = -1;
            if (idle) begin
                for (int k = 0; k < n; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
                    i = k;
`else
                    i = (m.ptr + k) % n;
`endif
                    if (g < 0 && vld[i]) g = i;
                end
            end
            exp_ready = (g >= 0) ? (1 << g) : 0;
            if (cyc == m.rsp_cyc) m.cur_data = m.pend_data;
            exp_rv = (cyc == m.rsp_cyc) ? (1 << m.rsp_req) : 0;
            chk({tag, "_req_ready"}, int'(ready), exp_ready);
            chk({tag, "_rom_en"}, int'(en), (cyc == m.en_cyc) ? 1 : 0);
            chk({tag, "_rom_addr"}, int'(raddr), m.addr_hold);
            chk({tag, "_rsp_valid"}, int'(rv), exp_rv);
            chk({tag, "_rsp_data"}, int'(rd), m.cur_data);
            chk({tag, "_busy"}, int'(bz), idle ? 0 : 1);
            if (g >= 0) begin
                av           = addrs[g*4 +: 4];
                dv           = ~av;
                m.en_cyc     = cyc + 1;
                m.rsp_cyc    = cyc + 2 + lat;
                m.busy_until = cyc + 2 + lat;
                m.rsp_req    = g;
                m.addr_hold  = int'(av);
                m.pend_data  = int'(dv);
                m.ptr        = (g + 1) % n;
            end
        end
        mo = m;
    endtask

    initial begin
        mdl_t t;
        forever begin
            @(negedge clk);
            mdl_cycle("A", ma, 2, 1, rst_a, {6'b0, va}, {24'b0, aa}, {6'b0, rdy_a}, en_a, radr_a,
                      {6'b0, rv_a}, rd_a, bz_a, t);
            ma = t;
            mdl_cycle("B", mb, 3, 3, rst_b, {5'b0, vb}, {20'b0, ab}, {5'b0, rdy_b}, en_b, radr_b,
                      {5'b0, rv_b}, rd_b, bz_b, t);
            mb = t;
            cyc++;
        end
    end

    function automatic int rdy(input bit b);
        return b ? int'(rdy_b) : int'(rdy_a);
    endfunction
    function automatic int rvv(input bit b);
        return b ? int'(rv_b) : int'(rv_a);
    endfunction
    function automatic int rdat(input bit b);
        return b ? int'(rd_b) : int'(rd_a);
    endfunction

    task automatic set_req(input bit b, input int i, input bit v, input logic [3:0] ad);
        if (b) begin
            vb[i] = v;
            ab[i*4 +: 4] = ad;
        end else begin
            va[i] = v;
            aa[i*4 +: 4] = ad;
        end
    endtask

    task automatic wait_ready(input bit b, input int i);
        bit got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            @(negedge clk);
            if (rdy(b) == (1 << i)) got = 1'b1;
        end
        chk("ready_seen", int'(got), 1);
    endtask

    // One read; lat counts cycles from the accept cycle to the response cycle.
    task automatic read_once(input bit b, input int i, input logic [3:0] ad,
                             output int lat, output int rv, output int dat);
        bit seen = 1'b0;
        @(posedge clk); #1;
        set_req(b, i, 1'b1, ad);
        wait_ready(b, i);
        @(posedge clk); #1;
        set_req(b, i, 1'b0, ad);
        lat = -1; rv = 0; dat = -1;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (rvv(b) != 0) begin
                seen = 1'b1; lat = n; rv = rvv(b); dat = rdat(b);
            end
        end
    endtask

    task automatic rst_pulse(input bit b);
        @(posedge clk); #1;
        if (b) rst_b = 1'b1; else rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
    endtask

    typedef struct {
        int         req;
        logic [3:0] addr;
        int         exp_rv;
        logic [3:0] exp_data;
    } vec_t;
    vec_t tbl [6];

    initial begin
        int lat, rv, dat, got, exp;
        logic [1:0] ra;
        logic [2:0] rb;
        bit stray;
        tbl[0] = '{0, 4'h3, 1, 4'hC};
        tbl[1] = '{1, 4'h0, 2, 4'hF};
        tbl[2] = '{0, 4'hF, 1, 4'h0};
        tbl[3] = '{1, 4'hA, 2, 4'h5};
        tbl[4] = '{0, 4'h5, 1, 4'hA};
        tbl[5] = '{1, 4'h6, 2, 4'h9};

        rst_a = 1'b1; rst_b = 1'b1;
        va = '0; vb = '0; aa = '0; ab = '0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        chk("reset_busy_a", int'(bz_a), 0);
        chk("reset_rom_en_a", int'(en_a), 0);
        chk("reset_rsp_valid_a", int'(rv_a), 0);
        chk("reset_rsp_data_b", int'(rd_b), 0);
        chk("reset_rom_addr_b", int'(radr_b), 0);

        // Single reads from a table.
        for (int k = 0; k < 6; k++) begin
            read_once(1'b0, tbl[k].req, tbl[k].addr, lat, rv, dat);
            chk("tbl_rsp_valid", rv, tbl[k].exp_rv);
            chk("tbl_rsp_data", dat, int'(tbl[k].exp_data));
            chk("tbl_latency", lat, 3);
            @(negedge clk);
            chk("tbl_busy_after_resp", int'(bz_a), 0);
        end

        // Contention with both requesters held: rr alternates, fixed priority starves req1.
        rst_pulse(1'b0);
        @(posedge clk); #1;
        va = 2'b11; aa = {4'h2, 4'h1};
        for (int g = 0; g < 4; g++) begin
            got = -1;
            for (int n = 0; n < 20 && got < 0; n++) begin
                @(negedge clk);
                if (rdy_a == 2'b01) got = 0;
                else if (rdy_a == 2'b10) got = 1;
            end
`ifdef ROM_ARB_FIXED_PRIO_EN
            exp = 0;
`else
            exp = g % 2;
`endif
            chk("contention_grant", got, exp);
        end
        @(posedge clk); #1;
        va = '0;
        repeat (6) @(posedge clk);

        // Withdrawn request: req1 raised while busy, dropped before IDLE.
        rst_pulse(1'b0);
        @(posedge clk); #1;
        set_req(1'b0, 0, 1'b1, 4'h7);
        wait_ready(1'b0, 0);
        @(posedge clk); #1;
        va = 2'b10; aa[7:4] = 4'h8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        va = 2'b00;
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rdy_a != 2'b00 || (en_a && radr_a == 4'h8)) stray = 1'b1;
        end
        chk("withdrawn_no_grant", int'(stray), 0);
        @(posedge clk); #1;
        va = 2'b11; aa = {4'h4, 4'h3};
        @(negedge clk);
`ifdef ROM_ARB_FIXED_PRIO_EN
        chk("withdrawn_ptr_kept", int'(rdy_a), 1);
`else
        chk("withdrawn_ptr_kept", int'(rdy_a), 2);
`endif
        @(posedge clk); #1;
        va = '0;
        repeat (6) @(posedge clk);

        // ROM_LAT=3, three requesters: req2 reads 4'hF; response 4 cycles after the accept edge.
        read_once(1'b1, 2, 4'hF, lat, rv, dat);
        chk("lat3_rsp_valid", rv, 4);
        chk("lat3_rsp_data", dat, 0);
        chk("lat3_latency", lat, 5);

        // Reset mid-read on B after advancing the pointer past req1.
        read_once(1'b1, 1, 4'h9, lat, rv, dat);
        chk("pre_abort_data", dat, 6);
        @(posedge clk); #1;
        set_req(1'b1, 1, 1'b1, 4'h4);
        wait_ready(1'b1, 1);
        @(posedge clk); #1;
        vb = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bz_b), 0);
        chk("abort_rom_en", int'(en_b), 0);
        chk("abort_rsp_valid", int'(rv_b), 0);
        stray = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rv_b != 3'b000) stray = 1'b1;
        end
        chk("abort_no_response", int'(stray), 0);
        @(posedge clk); #1;
        vb = 3'b110; ab = {4'h2, 4'h1, 4'h0};
        @(negedge clk);
        chk("abort_ptr_zero", int'(rdy_b), 2);
        @(posedge clk); #1;
        vb = '0;
        repeat (8) @(posedge clk);

        // Randomised traffic on both instances, checked cycle by cycle by the reference.
        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            ra = rdy_a; rb = rdy_b;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (va[i] && !ra[i]) begin
                    if ($urandom_range(7) == 0) va[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    va[i] = 1'b1; aa[i*4 +: 4] = 4'($urandom);
                end else begin
                    va[i] = 1'b0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (vb[i] && !rb[i]) begin
                    if ($urandom_range(7) == 0) vb[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    vb[i] = 1'b1; ab[i*4 +: 4] = 4'($urandom);
                end else begin
                    vb[i] = 1'b0;
                end
            end
            rst_a = ($urandom_range(299) == 0);
            rst_b = ($urandom_range(299) == 0);
        end
        @(posedge clk); #1;
        va = '0; vb = '0; rst_a = 1'b0; rst_b = 1'b0;
        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
